// File: rtl/duty_ramp_ctrl.sv
// Rate-limited duty driver for pwm_alu: steps duty_out by +/-1 toward a latched target, only at PWM-period boundaries.
// Optional RAMP_RETARGET_EN: targets are also accepted mid-ramp and the ramp re-aims (possibly reversing).
module duty_ramp_ctrl #(
  parameter int WIDTH        = 4,
  parameter int PERIOD       = 16,
  parameter int STEP_PERIODS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] duty_out,
  output logic             busy,
  output logic             at_target
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    period_cnt_q, period_cnt_d;
  logic [SW-1:0]    step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] tgt_eff;
  logic             accept;

  // Handshake outputs decode from state only, so ready never depends on valid.
`ifdef RAMP_RETARGET_EN
  assign tgt_ready = 1'b1;
`else
  assign tgt_ready = (state_q == IDLE);
`endif
  assign busy      = (state_q == RAMP);
  assign at_target = (state_q == IDLE);
  assign duty_out  = duty_q;
  assign accept    = tgt_valid && tgt_ready;

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    target_d     = target_q;
    period_cnt_d = period_cnt_q;
    step_cnt_d   = step_cnt_q;
    tgt_eff      = target_q;

    case (state_q)
      IDLE: begin
        period_cnt_d = '0;
        step_cnt_d   = '0;
        if (accept) begin
          target_d = tgt_data;
          if (tgt_data != duty_q) begin
            state_d = RAMP;
          end
        end
      end

      RAMP: begin
`ifdef RAMP_RETARGET_EN
        if (accept) begin
          target_d = tgt_data;
          tgt_eff  = tgt_data;
        end
`endif
        if (tgt_eff == duty_q) begin
          state_d      = IDLE;
          period_cnt_d = '0;
          step_cnt_d   = '0;
        end else if (period_cnt_q == PW'(PERIOD - 1)) begin
          // Period boundary: the only place duty_out may move.
          period_cnt_d = '0;
          if (step_cnt_q == SW'(STEP_PERIODS - 1)) begin
            step_cnt_d = '0;
            duty_d     = (tgt_eff > duty_q) ? duty_q + WIDTH'(1) : duty_q - WIDTH'(1);
            if (duty_d == tgt_eff) begin
              state_d = IDLE;
            end
          end else begin
            step_cnt_d = step_cnt_q + SW'(1);
          end
        end else begin
          period_cnt_d = period_cnt_q + PW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      target_q     <= '0;
      period_cnt_q <= '0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      period_cnt_q <= period_cnt_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl: expected duty steps and their cycle offsets are queued at accept time
// and popped as duty_out changes; handshake/status outputs are checked every cycle while watching.
module tb_duty_ramp_ctrl;

  localparam int WIDTH    = 4;
  localparam int CYC_STEP = 16 * 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tgt_valid = 1'b0;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data = '0;
  logic [WIDTH-1:0] duty_out;
  logic             busy;
  logic             at_target;

  typedef struct {
    int duty;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  duty_ramp_ctrl #(.WIDTH(WIDTH), .PERIOD(16), .STEP_PERIODS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .duty_out  (duty_out),
    .busy      (busy),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a target for one edge; returns at the negedge right after the accept edge (offset 0).
  task automatic send(input int d);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = WIDTH'(d);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic push_ramp(input int from, input int to);
    int d;
    int i;
    d = from;
    i = 0;
    while (d != to) begin
      d = (to > d) ? d + 1 : d - 1;
      i++;
      exp_q.push_back('{duty: d, cyc: i * CYC_STEP});
    end
  endtask

  // Observe cycles (from, to] after the accept edge, matching each duty change against the queue.
  task automatic watch(input int from, input int to);
    logic [WIDTH-1:0] prev;
    exp_t e;
    prev = duty_out;
    for (int k = from + 1; k <= to; k++) begin
      @(negedge clk);
      if (duty_out !== prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 32'(duty_out), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          check("step_duty", 32'(duty_out), 32'(e.duty));
          check("step_cycle", 32'(k), 32'(e.cyc));
        end
      end
      prev = duty_out;
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("at_target", 32'(at_target), 32'(exp_q.size() == 0));
`ifdef RAMP_RETARGET_EN
      check("tgt_ready", 32'(tgt_ready), 32'd1);
`else
      check("tgt_ready", 32'(tgt_ready), 32'(exp_q.size() == 0));
`endif
    end
  endtask

  task automatic expect_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // 1. asynchronous reset with no clock edge yet
    #1 rst = 1'b0;
    #1;
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_ready", 32'(tgt_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_at_target", 32'(at_target), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 2. ramp up 0 -> 5
    send(5);
    check("up_busy_t0", 32'(busy), 32'd1);
    check("up_ready_t0", 32'(tgt_ready), 32'(`ifdef RAMP_RETARGET_EN 1 `else 0 `endif));
    push_ramp(0, 5);
    watch(0, 5 * CYC_STEP + 8);
    expect_drained("up_drained");
    check("up_final", 32'(duty_out), 32'd5);

    // 3. ramp down 5 -> 2
    send(2);
    push_ramp(5, 2);
    watch(0, 3 * CYC_STEP + 8);
    expect_drained("down_drained");
    check("down_final", 32'(duty_out), 32'd2);

    // 4. step to 3, then a null request for 3
    send(3);
    push_ramp(2, 3);
    watch(0, CYC_STEP + 4);
    expect_drained("to3_drained");
    send(3);
    check("null_busy", 32'(busy), 32'd0);
    check("null_ready", 32'(tgt_ready), 32'd1);
    check("null_duty", 32'(duty_out), 32'd3);
    watch(0, 40);

    // 5. target presented mid-ramp 0 -> 5
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    check("mid_rst_duty", 32'(duty_out), 32'd0);
    send(5);
    push_ramp(0, 5);
    watch(0, 39);
    check("mid_duty39", 32'(duty_out), 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = WIDTH'(1);
`ifdef RAMP_RETARGET_EN
    exp_q.delete();
    watch(39, 40);
    tgt_valid = 1'b0;
    check("retarget_duty", 32'(duty_out), 32'd1);
    check("retarget_busy", 32'(busy), 32'd0);
    watch(40, 100);
`else
    check("norretarget_ready", 32'(tgt_ready), 32'd0);
    watch(39, 45);
    tgt_valid = 1'b0;
    watch(45, 5 * CYC_STEP + 8);
    expect_drained("noretarget_drained");
    check("noretarget_final", 32'(duty_out), 32'd5);
`endif

    // 6. reset mid-ramp 0 -> 15 at duty 7
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    send(15);
    push_ramp(0, 15);
    watch(0, 7 * CYC_STEP + 6);
    check("pre_rst_duty", 32'(duty_out), 32'd7);
    #2 rst = 1'b0;
    #1;
    check("async_rst_duty", 32'(duty_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(tgt_ready), 32'd1);
    check("async_rst_at_target", 32'(at_target), 32'd1);
    exp_q.delete();
    @(negedge clk);
    check("held_rst_duty", 32'(duty_out), 32'd0);
    rst = 1'b1;
    send(2);
    push_ramp(0, 2);
    watch(0, 2 * CYC_STEP + 8);
    expect_drained("post_rst_drained");
    check("post_rst_final", 32'(duty_out), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
